// File: rtl/memory_controller_if.sv
// ---------------------------------------------------------------------------
// interface_memory_controller
// Bus bundle between the w8086 BIU and its backing-store memory controller.
// The controller sits on the master modport, the BIU on the slave modport.
//   read_enable   : read request, sampled on each rising clock edge
//   read_address  : byte address of the low byte of the word to read
//   read_data     : registered little-endian read word {mem[a+1], mem[a]}
//   read_valid    : one-cycle pulse marking read_data as freshly updated
//   write_enable  : write request, sampled on each rising clock edge
//   write_address : byte address of the low byte of the word to write
//   write_data    : word to write, [7:0] to a and [15:8] to a+1
// ---------------------------------------------------------------------------
interface interface_memory_controller #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16
);

  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] read_address;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_valid;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;

  modport master (
    input  read_enable,
    input  read_address,
    input  write_enable,
    input  write_address,
    input  write_data,
    output read_data,
    output read_valid
  );

  modport slave (
    output read_enable,
    output read_address,
    output write_enable,
    output write_address,
    output write_data,
    input  read_data,
    input  read_valid
  );

endinterface

// File: rtl/memory_controller.sv
// ---------------------------------------------------------------------------
// memory_controller
// On-chip byte-addressed memory behind the w8086 BIU. One independent read
// port and one independent write port, each moving a 16-bit little-endian
// word per cycle at any (even or odd) byte address. Reads are registered with
// one cycle of latency; writes land on the requesting edge. Only the low
// MEM_ADDR_BITS address bits are decoded, so higher addresses alias.
// Ports:
//   clock : sole clock, rising-edge sampling
//   reset : asynchronous, active-low; clears read_data/read_valid only,
//           memory contents are kept
//   bus   : interface_memory_controller.master (read/write request bundle)
// ---------------------------------------------------------------------------
module memory_controller #(
  parameter int ADDR_WIDTH    = 20,
  parameter int DATA_WIDTH    = 16,
  parameter int MEM_ADDR_BITS = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  interface_memory_controller.master  bus
);

  localparam int ROW_BITS = MEM_ADDR_BITS - 1;
  localparam int DEPTH    = 1 << ROW_BITS;

  // Storage is split into an even-byte bank and an odd-byte bank so that any
  // word, aligned or not, touches exactly one entry of each bank per cycle.
  // Both banks power up cleared; reset never touches them.
  logic [7:0] evenBank [DEPTH] = '{default: 8'h00};
  logic [7:0] oddBank  [DEPTH] = '{default: 8'h00};

  logic [MEM_ADDR_BITS-1:0] rdAddr, wrAddr;
  logic [ROW_BITS-1:0]      rdRow, rdRowNext, wrRow, wrRowNext;
  logic [7:0]               rdLow, rdHigh;

  logic [DATA_WIDTH-1:0] readData_q, readData_d;
  logic                  readValid_q, readValid_d;

  // Address bits above the decoded range are deliberately ignored (aliasing).
  logic unusedAddrBits;
  assign unusedAddrBits = ^{bus.read_address[ADDR_WIDTH-1:MEM_ADDR_BITS],
                            bus.write_address[ADDR_WIDTH-1:MEM_ADDR_BITS]};

  // Address steering. For an odd address the low byte lives in the odd bank
  // at row a>>1 and the high byte in the even bank one row further on; the
  // row increment wraps naturally, so the top byte's partner is byte 0.
  always_comb begin
    rdAddr    = bus.read_address[MEM_ADDR_BITS-1:0];
    wrAddr    = bus.write_address[MEM_ADDR_BITS-1:0];
    rdRow     = rdAddr[MEM_ADDR_BITS-1:1];
    wrRow     = wrAddr[MEM_ADDR_BITS-1:1];
    rdRowNext = rdRow + ROW_BITS'(1);
    wrRowNext = wrRow + ROW_BITS'(1);
    if (rdAddr[0]) begin
      rdLow  = oddBank[rdRow];
      rdHigh = evenBank[rdRowNext];
    end else begin
      rdLow  = evenBank[rdRow];
      rdHigh = oddBank[rdRow];
    end
  end

  // Next-state for the read response: latch a new word on a request,
  // otherwise hold the last word and drop the valid pulse.
  always_comb begin
    readData_d  = readData_q;
    readValid_d = bus.read_enable;
    if (bus.read_enable) begin
      readData_d = {rdHigh, rdLow};
    end
  end

  // Write port. Gating on reset drops a write whose edge coincides with an
  // asserted reset. Since the read mux samples the banks before this edge
  // updates them, a same-cycle overlapping read sees the old contents.
  always_ff @(posedge clock) begin
    if (reset && bus.write_enable) begin
      if (wrAddr[0]) begin
        oddBank[wrRow]      <= bus.write_data[7:0];
        evenBank[wrRowNext] <= bus.write_data[15:8];
      end else begin
        evenBank[wrRow]     <= bus.write_data[7:0];
        oddBank[wrRow]      <= bus.write_data[15:8];
      end
    end
  end

  // Registered read response with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      readData_q  <= '0;
      readValid_q <= 1'b0;
    end else begin
      readData_q  <= readData_d;
      readValid_q <= readValid_d;
    end
  end

  assign bus.read_data  = readData_q;
  assign bus.read_valid = readValid_q;

endmodule

// File: tb/tb_memory_controller.sv
// ---------------------------------------------------------------------------
// tb_memory_controller
// Directed bench for memory_controller: reset values, word write/readback,
// unaligned overlap, address aliasing, top-byte wrap, read-before-write on a
// same-cycle collision, back-to-back reads, and mid-stream async reset.
// ---------------------------------------------------------------------------
module tb_memory_controller;

  logic clock;
  logic reset;
  int   totalChecks;
  int   badChecks;

  interface_memory_controller busIf ();

  memory_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (busIf.master)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts every comparison and reports any mismatch on one line.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one request cycle starting at a falling edge, then idles the
  // request lines at the following falling edge, where outputs are sampled.
  task automatic applyStimulus(input logic we, input logic [19:0] wAddr,
                               input logic [15:0] wData, input logic re,
                               input logic [19:0] rAddr);
    @(negedge clock);
    busIf.write_enable  = we;
    busIf.write_address = wAddr;
    busIf.write_data    = wData;
    busIf.read_enable   = re;
    busIf.read_address  = rAddr;
    @(negedge clock);
    busIf.write_enable  = 1'b0;
    busIf.read_enable   = 1'b0;
  endtask

  // Convenience wrappers around applyStimulus.
  task automatic writeWord(input logic [19:0] addr, input logic [15:0] data);
    applyStimulus(1'b1, addr, data, 1'b0, 20'h0);
  endtask

  task automatic readWord(input string tag, input logic [19:0] addr,
                          input logic [15:0] expected);
    applyStimulus(1'b0, 20'h0, 16'h0, 1'b1, addr);
    checkOutput(tag, 32'(busIf.read_data), 32'(expected));
    checkOutput({tag, "_valid"}, 32'(busIf.read_valid), 32'd1);
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    reset                = 1'b0;
    busIf.read_enable    = 1'b0;
    busIf.read_address   = '0;
    busIf.write_enable   = 1'b0;
    busIf.write_address  = '0;
    busIf.write_data     = '0;

    // Reset held across several edges.
    repeat (3) @(negedge clock);
    checkOutput("rst_data", 32'(busIf.read_data), 32'h0000);
    checkOutput("rst_valid", 32'(busIf.read_valid), 32'd0);
    reset = 1'b1;

    // First read after release: memory starts cleared, valid pulses once.
    readWord("first_rd", 20'h00001, 16'h0000);
    @(negedge clock);
    checkOutput("first_rd_pulse_end", 32'(busIf.read_valid), 32'd0);

    // Word write/readback.
    writeWord(20'h00001, 16'h0001);
    writeWord(20'h00010, 16'h0010);
    readWord("rd_01", 20'h00001, 16'h0001);
    readWord("rd_10", 20'h00010, 16'h0010);

    // Back-to-back unaligned-overlap reads: valid stays high, data changes.
    @(negedge clock);
    busIf.read_enable  = 1'b1;
    busIf.read_address = 20'h00000;
    @(negedge clock);
    checkOutput("b2b_rd_00", 32'(busIf.read_data), 32'h0100);
    checkOutput("b2b_valid_a", 32'(busIf.read_valid), 32'd1);
    busIf.read_address = 20'h00002;
    @(negedge clock);
    checkOutput("b2b_rd_02", 32'(busIf.read_data), 32'h0000);
    checkOutput("b2b_valid_b", 32'(busIf.read_valid), 32'd1);
    busIf.read_enable = 1'b0;
    @(negedge clock);
    checkOutput("idle_valid", 32'(busIf.read_valid), 32'd0);
    checkOutput("idle_hold", 32'(busIf.read_data), 32'h0000);

    // Aliasing: 0x10010 maps onto 0x00010.
    writeWord(20'h10010, 16'hBEEF);
    readWord("alias_rd", 20'h00010, 16'hBEEF);

    // Top-byte wrap: mem[FFFF]=5A, mem[0000]=A5.
    writeWord(20'h0FFFF, 16'hA55A);
    readWord("wrap_rd_00", 20'h00000, 16'h01A5);
    readWord("wrap_rd_ffff", 20'h0FFFF, 16'hA55A);
    readWord("wrap_rd_fffe", 20'h0FFFE, 16'h5A00);

    // Same-cycle read and write to one word: old data first, new data next.
    writeWord(20'h00020, 16'h1234);
    applyStimulus(1'b1, 20'h00020, 16'h5678, 1'b1, 20'h00020);
    checkOutput("rbw_old", 32'(busIf.read_data), 32'h1234);
    readWord("rbw_new", 20'h00020, 16'h5678);
    readWord("rbw_odd", 20'h00021, 16'h0056);

    // Mid-stream asynchronous reset between edges.
    writeWord(20'h00040, 16'hCAFE);
    readWord("pre_rst_rd", 20'h00040, 16'hCAFE);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_data", 32'(busIf.read_data), 32'h0000);
    checkOutput("async_rst_valid", 32'(busIf.read_valid), 32'd0);

    // A write (and read) on an edge while reset is asserted is ignored.
    @(negedge clock);
    busIf.write_enable  = 1'b1;
    busIf.write_address = 20'h00040;
    busIf.write_data    = 16'hDEAD;
    busIf.read_enable   = 1'b1;
    busIf.read_address  = 20'h00040;
    @(negedge clock);
    busIf.write_enable = 1'b0;
    busIf.read_enable  = 1'b0;
    checkOutput("rst_held_valid", 32'(busIf.read_valid), 32'd0);
    checkOutput("rst_held_data", 32'(busIf.read_data), 32'h0000);
    reset = 1'b1;

    readWord("retain_rd", 20'h00040, 16'hCAFE);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
